// File: rtl/kf8237_pkg.sv
// Shared definitions for the KF8237 DMA timing and control block.
//   state_e          : transfer sequencer states (SI idle, S0 hold request, S1..S4 word cycle)
//   MODE_* / TYPE_*  : transfer_mode and transfer_type encodings
//   CH_W             : number of DMA channels (one-hot width)
package kf8237_pkg;

  localparam int unsigned CH_W = 4;

  typedef enum logic [2:0] {
    ST_SI = 3'd0,
    ST_S0 = 3'd1,
    ST_S1 = 3'd2,
    ST_S2 = 3'd3,
    ST_S3 = 3'd4,
    ST_S4 = 3'd5
  } state_e;

  // transfer_mode encodings; 2'b11 is reserved and behaves as single
  localparam logic [1:0] MODE_DEMAND = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_BLOCK  = 2'b10;

  // transfer_type encodings; 2'b11 is reserved and behaves as verify
  localparam logic [1:0] TYPE_VERIFY = 2'b00;
  localparam logic [1:0] TYPE_WRITE  = 2'b01;
  localparam logic [1:0] TYPE_READ   = 2'b10;

endpackage

// File: rtl/kf8237_timing_and_control.sv
// KF8237 DMA timing and control: sequences SI/S0/S1/S2/S3/S4 per word and
// drives the bus handshake, strobes, and address/count register controls.
// Inputs : clock, reset (sync, active-low), dma_request_grant (one-hot),
//          dma_request_active, hold_acknowledge, ready, transfer_mode,
//          transfer_type, auto_initialize, underflow, end_of_process_n_in.
// Outputs: hold_request, dma_acknowledge, transfer_register_select, next_word,
//          initialize_current_register, address_strobe, memory/io strobes
//          (active-low), end_of_process_n_out, terminal_count. All registered.
module kf8237_timing_and_control
  import kf8237_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [CH_W-1:0] dma_request_grant,
  input  logic            dma_request_active,
  input  logic            hold_acknowledge,
  input  logic            ready,
  input  logic [1:0]      transfer_mode,
  input  logic [1:0]      transfer_type,
  input  logic            auto_initialize,
  input  logic            underflow,
  input  logic            end_of_process_n_in,
  output logic            hold_request,
  output logic [CH_W-1:0] dma_acknowledge,
  output logic [CH_W-1:0] transfer_register_select,
  output logic            next_word,
  output logic            initialize_current_register,
  output logic            address_strobe,
  output logic            memory_read_n,
  output logic            memory_write_n,
  output logic            io_read_n,
  output logic            io_write_n,
  output logic            end_of_process_n_out,
  output logic [CH_W-1:0] terminal_count
);

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            term_q, term_d;

  logic            hrq_q, hrq_d;
  logic [CH_W-1:0] dack_q, dack_d;
  logic [CH_W-1:0] trs_q, trs_d;
  logic            nw_q, nw_d;
  logic            init_q, init_d;
  logic            adstb_q, adstb_d;
  logic            memr_n_q, memr_n_d;
  logic            memw_n_q, memw_n_d;
  logic            ior_n_q, ior_n_d;
  logic            iow_n_q, iow_n_d;
  logic            eop_n_q, eop_n_d;
  logic [CH_W-1:0] tc_q, tc_d;

  logic            rd_phase;
  logic            wr_phase;
  logic            in_service;

  // Next-state logic; outputs are decoded from the next state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    term_d   = term_q;
    nw_d     = 1'b0;
    init_d   = 1'b0;
    eop_n_d  = 1'b1;
    tc_d     = '0;

    case (state_q)
      ST_SI: begin
        if (dma_request_grant != '0) begin
          state_d = ST_S0;
          ch_d    = dma_request_grant;
        end
      end
      ST_S0: begin
        if (hold_acknowledge) begin
          state_d = ST_S1;
        end else if ((dma_request_grant & ch_q) == '0) begin
          state_d = ST_SI;
        end
      end
      ST_S1: begin
        state_d = ST_S2;
      end
      ST_S2: begin
        state_d = ST_S3;
        if (!end_of_process_n_in) term_d = 1'b1;
      end
      ST_S3: begin
        if (!end_of_process_n_in) term_d = 1'b1;
        if (ready) begin
          // underflow is qualified on the S3->S4 edge so EOP/TC can be
          // presented as registered outputs during S4 itself
          state_d = ST_S4;
          nw_d    = 1'b1;
          if (underflow) begin
            term_d = 1'b1;
            tc_d   = ch_q;
          end
          eop_n_d = !term_d;
        end
      end
      ST_S4: begin
        term_d = 1'b0;
        if (term_q || !end_of_process_n_in) begin
          state_d = ST_SI;
          init_d  = auto_initialize;
        end else begin
          case (transfer_mode)
            MODE_BLOCK:  state_d = ST_S1;
            MODE_DEMAND: state_d = dma_request_active ? ST_S1 : ST_SI;
            default:     state_d = ST_SI;
          endcase
        end
      end
      default: begin
        state_d = ST_SI;
        term_d  = 1'b0;
      end
    endcase

    in_service = (state_d == ST_S1) || (state_d == ST_S2) ||
                 (state_d == ST_S3) || (state_d == ST_S4);
    rd_phase   = (state_d == ST_S2) || (state_d == ST_S3);
    wr_phase   = (state_d == ST_S3);

    hrq_d    = (state_d != ST_SI);
    dack_d   = in_service ? ch_d : '0;
    trs_d    = in_service ? ch_d : '0;
    adstb_d  = (state_d == ST_S1);
    memr_n_d = !(rd_phase && (transfer_type == TYPE_READ));
    ior_n_d  = !(rd_phase && (transfer_type == TYPE_WRITE));
    memw_n_d = !(wr_phase && (transfer_type == TYPE_WRITE));
    iow_n_d  = !(wr_phase && (transfer_type == TYPE_READ));
  end

  // State and output registers; reset aborts any transfer without pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_SI;
      ch_q     <= '0;
      term_q   <= 1'b0;
      hrq_q    <= 1'b0;
      dack_q   <= '0;
      trs_q    <= '0;
      nw_q     <= 1'b0;
      init_q   <= 1'b0;
      adstb_q  <= 1'b0;
      memr_n_q <= 1'b1;
      memw_n_q <= 1'b1;
      ior_n_q  <= 1'b1;
      iow_n_q  <= 1'b1;
      eop_n_q  <= 1'b1;
      tc_q     <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      term_q   <= term_d;
      hrq_q    <= hrq_d;
      dack_q   <= dack_d;
      trs_q    <= trs_d;
      nw_q     <= nw_d;
      init_q   <= init_d;
      adstb_q  <= adstb_d;
      memr_n_q <= memr_n_d;
      memw_n_q <= memw_n_d;
      ior_n_q  <= ior_n_d;
      iow_n_q  <= iow_n_d;
      eop_n_q  <= eop_n_d;
      tc_q     <= tc_d;
    end
  end

  assign hold_request                = hrq_q;
  assign dma_acknowledge             = dack_q;
  assign transfer_register_select    = trs_q;
  assign next_word                   = nw_q;
  assign initialize_current_register = init_q;
  assign address_strobe              = adstb_q;
  assign memory_read_n               = memr_n_q;
  assign memory_write_n              = memw_n_q;
  assign io_read_n                   = ior_n_q;
  assign io_write_n                  = iow_n_q;
  assign end_of_process_n_out        = eop_n_q;
  assign terminal_count              = tc_q;

endmodule
